keymem_req_arbiter: RTL and testbench

// - Shares one keymem_top key lookup port (key_req/key_id/key/key_ack, clk156 domain) between NUM_REQ network_path requesters.
// - Round-robin grant, one lookup outstanding at a time; key bus and ack are routed back to the granted requester only.
// - Watchdog aborts lookups the key memory never acknowledges, so a requester cannot hang.

---
 rtl/keymem_pkg.sv | 20 ++
 rtl/keymem_req_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/keymem_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_keymem_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keymem_pkg.sv
// Shared definitions for the keymem lookup-port arbiter: FSM encodings, default
// bus widths and the abort counter width.
package keymem_pkg;

  localparam int unsigned KeyW    = 256;
  localparam int unsigned KeyIdW  = 32;
  localparam int unsigned TmoCntW = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StResp  = 2'd3;

  function automatic logic [TmoCntW-1:0] sat_inc(input logic [TmoCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/keymem_req_arbiter_if.sv
// Requester-side and keymem-side lookup signals of the arbiter, bundled.
// master = arbiter view, slave = requesters plus key memory.
interface keymem_req_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned KEY_ID_W = 32,
  parameter int unsigned KEY_W    = 256
);

  logic [NUM_REQ-1:0]          rq_key_req;
  logic [NUM_REQ*KEY_ID_W-1:0] rq_key_id;
  logic [NUM_REQ-1:0]          rq_key_ack;
  logic [NUM_REQ-1:0]          rq_key_err;
  logic [KEY_W-1:0]            rq_key;
  logic                        km_key_req;
  logic [KEY_ID_W-1:0]         km_key_id;
  logic                        km_key_ack;
  logic [KEY_W-1:0]            km_key;

  modport master (
    input  rq_key_req, rq_key_id, km_key_ack, km_key,
    output rq_key_ack, rq_key_err, rq_key, km_key_req, km_key_id
  );

  modport slave (
    output rq_key_req, rq_key_id, km_key_ack, km_key,
    input  rq_key_ack, rq_key_err, rq_key, km_key_req, km_key_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      int            sum;
      logic [PtrW-1:0] idx;
      sum = int'(ptr_i) + i;
      if (sum >= int'(NUM_REQ)) begin
        sum = sum - int'(NUM_REQ);
      end
      idx = PtrW'(sum);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keymem_req_arbiter.sv
// Shares one keymem lookup port among NUM_REQ requesters: round-robin grant,
// one lookup in flight, watchdog abort with a saturating abort counter.
module keymem_req_arbiter
  import keymem_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned KEY_ID_W = KeyIdW,
  parameter int unsigned KEY_W    = KeyW,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                 clk156,
  input  logic                 areset_clk156,
  keymem_req_arbiter_if.master bus,
  output logic                 busy,
  output logic [TmoCntW-1:0]   timeout_count
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [KEY_ID_W-1:0] id_q, id_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                err_q, err_d;
  logic [TmoCntW-1:0]  wdog_q, wdog_d;
  logic [TmoCntW-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_valid;
  logic [IdxW-1:0]     gnt_idx;
  logic [KEY_ID_W-1:0] gnt_id;
  logic                expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (IdxW)
  ) u_rr_arbiter (
    .req_i   (bus.rq_key_req),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_id  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx = IdxW'(i);
        gnt_id  = bus.rq_key_id[i*KEY_ID_W +: KEY_ID_W];
      end
    end
  end

  // wdog_q counts completed WAIT cycles, so this is the TIMEOUT-th WAIT cycle.
  assign expired = (wdog_q == TmoCntW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    key_d     = key_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    tmo_cnt_d = tmo_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          gnt_idx_d = gnt_idx;
          id_d      = gnt_id;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        err_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.km_key_ack) begin
          key_d   = bus.km_key;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (expired) begin
          key_d     = '0;
          err_d     = 1'b1;
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          state_d   = StResp;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        key_d   = '0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      key_q     <= key_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    bus.rq_key_ack = '0;
    if (state_q == StResp) begin
      bus.rq_key_ack[gnt_idx_q] = 1'b1;
    end
    bus.rq_key_err = bus.rq_key_ack & {NUM_REQ{err_q}};
  end

  assign bus.rq_key     = key_q;
  assign bus.km_key_req = (state_q == StIssue);
  assign bus.km_key_id  = id_q;
  assign busy           = (state_q != StIdle);
  assign timeout_count  = tmo_cnt_q;

endmodule

// File: tb/tb_keymem_req_arbiter.sv
// Scoreboard bench for keymem_req_arbiter: stimulus pushes expected acks,
// a monitor pops and compares them whenever rq_key_ack fires.
module tb_keymem_req_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned IdW  = 32;
  localparam int unsigned KW   = 256;

  typedef struct {
    logic [NReq-1:0] ack;
    logic [NReq-1:0] err;
    logic [KW-1:0]   key;
    int              cyc;
    string           name;
  } exp_t;

  logic        clk156;
  logic        areset_clk156;
  logic        busy;
  logic [15:0] timeout_count;

  int n_cmp;
  int n_bad;
  int cyc;
  int kmreq_n;
  exp_t exp_q[$];

  // keymem model controls
  int          km_delay;
  int          km_cnt;
  bit          key_from_id;
  logic [KW-1:0] key_val;
  logic        model_ack;
  logic [KW-1:0] model_key;
  logic        spur_ack;
  logic [KW-1:0] spur_key;

  keymem_req_arbiter_if #(.NUM_REQ(NReq), .KEY_ID_W(IdW), .KEY_W(KW)) bus ();

  keymem_req_arbiter #(
    .NUM_REQ  (NReq),
    .KEY_ID_W (IdW),
    .KEY_W    (KW),
    .TIMEOUT  (8)
  ) dut (
    .clk156        (clk156),
    .areset_clk156 (areset_clk156),
    .bus           (bus),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  assign bus.km_key_ack = model_ack | spur_ack;
  assign bus.km_key     = model_key | spur_key;

  initial begin
    clk156 = 1'b0;
    forever #5 clk156 = ~clk156;
  end

  always @(posedge clk156) cyc <= cyc + 1;

  // Ack d cycles after the km_key_req pulse; d = 0 means never.
  always @(negedge clk156) begin
    if (model_ack) begin
      model_ack <= 1'b0;
      model_key <= '0;
    end
    if (bus.km_key_req) begin
      km_cnt <= km_delay;
    end else if (km_cnt > 0) begin
      km_cnt <= km_cnt - 1;
      if (km_cnt == 1) begin
        model_ack <= 1'b1;
        model_key <= key_from_id ? {8{bus.km_key_id}} : key_val;
      end
    end
  end

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk156);
      if (bus.km_key_req) kmreq_n++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk156);
      if (|(bus.rq_key_err & ~bus.rq_key_ack)) begin
        check("err_without_ack", KW'(bus.rq_key_err), '0);
      end
      if (|bus.rq_key_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", KW'(bus.rq_key_ack), '0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_ack"}, KW'(bus.rq_key_ack), KW'(e.ack));
          check({e.name, "_err"}, KW'(bus.rq_key_err), KW'(e.err));
          check({e.name, "_key"}, bus.rq_key, e.key);
          check({e.name, "_cycle"}, KW'(cyc), KW'(e.cyc));
        end
      end
    end
  end

  task automatic push(input logic [NReq-1:0] ack, input logic [NReq-1:0] err,
                      input logic [KW-1:0] key, input int at, input string name);
    exp_t e;
    e.ack  = ack;
    e.err  = err;
    e.key  = key;
    e.cyc  = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input bit drop, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk156);
      n++;
    end while (!(|bus.rq_key_ack) && n < 40);
    if (!(|bus.rq_key_ack)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_wait: got no ack within %0d cycles", name, n);
    end else if (drop) begin
      bus.rq_key_req = '0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ack"}, KW'(bus.rq_key_ack), '0);
    check({name, "_key"}, bus.rq_key, '0);
    check({name, "_kmreq"}, KW'(bus.km_key_req), '0);
    check({name, "_kmid"}, KW'(bus.km_key_id), '0);
    check({name, "_busy"}, KW'(busy), '0);
    check({name, "_tmo"}, KW'(timeout_count), '0);
  endtask

  initial begin
    int t;
    int k0;
    n_cmp = 0; n_bad = 0; cyc = 0; kmreq_n = 0;
    km_delay = 0; km_cnt = 0; key_from_id = 0; key_val = '0;
    model_ack = 0; model_key = '0; spur_ack = 0; spur_key = '0;
    bus.rq_key_req = '0;
    bus.rq_key_id  = '0;
    areset_clk156  = 1'b1;
    repeat (3) @(negedge clk156);
    check_idle_outputs("reset");
    areset_clk156 = 1'b0;
    repeat (2) @(negedge clk156);

    // Contention: grant order 0,1,2,3,0 with 4-cycle ack spacing.
    for (int i = 0; i < int'(NReq); i++) bus.rq_key_id[i*IdW +: IdW] = 32'hC0DE_0000 + i;
    key_from_id = 1; km_delay = 1; k0 = kmreq_n;
    t = cyc;
    bus.rq_key_req = 4'b1111;
    push(4'b0001, '0, {8{32'hC0DE_0000}}, t + 3,  "cont0");
    push(4'b0010, '0, {8{32'hC0DE_0001}}, t + 7,  "cont1");
    push(4'b0100, '0, {8{32'hC0DE_0002}}, t + 11, "cont2");
    push(4'b1000, '0, {8{32'hC0DE_0003}}, t + 15, "cont3");
    push(4'b0001, '0, {8{32'hC0DE_0000}}, t + 19, "cont4");
    for (int i = 0; i < 5; i++) wait_ack(i == 4, "cont");
    @(negedge clk156);
    check("cont_kmreq_pulses", KW'(kmreq_n - k0), KW'(5));
    key_from_id = 0;

    // Single request, keymem acks 3 cycles after km_key_req.
    bus.rq_key_id = '0;
    bus.rq_key_id[0 +: IdW] = 32'h0000_00A5;
    key_val = {8{32'h1111_1111}}; km_delay = 3; k0 = kmreq_n;
    t = cyc;
    bus.rq_key_req = 4'b0001;
    push(4'b0001, '0, {8{32'h1111_1111}}, t + 5, "single");
    @(negedge clk156);
    check("single_kmreq", KW'(bus.km_key_req), KW'(1));
    check("single_kmid", KW'(bus.km_key_id), KW'(32'hA5));
    wait_ack(1, "single");
    @(negedge clk156);
    check("single_kmreq_pulses", KW'(kmreq_n - k0), KW'(1));
    check("single_key_cleared", bus.rq_key, '0);
    check("single_busy_after", KW'(busy), '0);

    // Timeout: keymem never acks requester 1.
    bus.rq_key_id[1*IdW +: IdW] = 32'h0000_0BAD;
    km_delay = 0;
    t = cyc;
    bus.rq_key_req = 4'b0010;
    push(4'b0010, 4'b0010, '0, t + 10, "timeout");
    wait_ack(1, "timeout");
    @(negedge clk156);
    check("timeout_count_1", KW'(timeout_count), KW'(1));

    // Normal service after the abort.
    bus.rq_key_id[2*IdW +: IdW] = 32'h0000_0077;
    key_val = {8{32'h2222_2222}}; km_delay = 2;
    t = cyc;
    bus.rq_key_req = 4'b0100;
    push(4'b0100, '0, {8{32'h2222_2222}}, t + 4, "after_tmo");
    wait_ack(1, "after_tmo");
    @(negedge clk156);

    // Race: ack lands in the watchdog-expiry cycle; the ack wins.
    bus.rq_key_id[3*IdW +: IdW] = 32'h0000_0033;
    key_val = {8{32'h3333_3333}}; km_delay = 8;
    t = cyc;
    bus.rq_key_req = 4'b1000;
    push(4'b1000, '0, {8{32'h3333_3333}}, t + 10, "race");
    wait_ack(1, "race");
    @(negedge clk156);
    check("race_timeout_count", KW'(timeout_count), KW'(1));

    // Reset mid-WAIT; the late ack must be ignored.
    bus.rq_key_id[0 +: IdW] = 32'h0000_005A;
    key_val = {8{32'h4444_4444}}; km_delay = 6;
    bus.rq_key_req = 4'b0001;
    repeat (3) @(negedge clk156);
    check("pre_reset_busy", KW'(busy), KW'(1));
    areset_clk156 = 1'b1;
    @(negedge clk156);
    check_idle_outputs("mid_reset");
    @(negedge clk156);
    areset_clk156  = 1'b0;
    bus.rq_key_req = '0;
    repeat (5) @(negedge clk156);
    check("post_reset_busy", KW'(busy), '0);
    check("post_reset_key", bus.rq_key, '0);

    // Spurious ack in IDLE.
    spur_ack = 1'b1;
    spur_key = {8{32'hDEAD_BEEF}};
    @(negedge clk156);
    spur_ack = 1'b0;
    spur_key = '0;
    repeat (2) @(negedge clk156);
    check("spur_key", bus.rq_key, '0);
    check("spur_busy", KW'(busy), '0);

    repeat (2) @(negedge clk156);
    check("scoreboard_drained", KW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
